// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizing for the data-memory arbiter.
// Holds the FSM state type, default widths and counter sizing.
package dmem_arbiter_pkg;

    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 8;
    localparam int MAX_WAIT_DEF  = 4;
    localparam int MAX_BURST_DEF = 8;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int WAIT_CW  = cnt_width(MAX_WAIT_DEF);
    localparam int BURST_CW = cnt_width(MAX_BURST_DEF);

    typedef enum logic {
        ARB    = 1'b0,
        HBURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module arb_sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CMAX = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CMAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between CPU datapath and host.
// Host starvation bounded by wait_cnt, host bursts by burst_cnt.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic [DW-1:0] c_rdata,
    output logic          stall,
    input  logic          h_req,
    input  logic          h_we,
    input  logic          h_lock,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic [DW-1:0] h_rdata,
    output logic          h_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam int WCW = cnt_width(MAX_WAIT);
    localparam int BCW = cnt_width(MAX_BURST);
    localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);
    localparam logic [BCW-1:0] BMAX = BCW'(MAX_BURST);

    arb_state_t     state;
    arb_state_t     nxt;
    logic [WCW-1:0] wait_cnt;
    logic [BCW-1:0] burst_cnt;
    logic           host_force;
    logic           arb_c;
    logic           arb_h;
    logic           c_sel;
    logic           h_sel;

    always_comb begin
        host_force = h_req && (wait_cnt == WMAX);
        arb_h      = host_force || (!c_req && h_req);
        arb_c      = c_req && !host_force;
        c_sel      = 1'b0;
        h_sel      = 1'b0;
        nxt        = ARB;
        unique case (state)
            ARB: begin
                c_sel = arb_c;
                h_sel = arb_h;
                if (arb_h && h_lock) nxt = HBURST;
            end
            HBURST: begin
                if (h_req && h_lock && (burst_cnt < BMAX)) begin
                    h_sel = 1'b1;
                    nxt   = HBURST;
                end else if ((burst_cnt == BMAX) && c_req) begin
                    c_sel = 1'b1;
                // no pending CPU: a saturated burst keeps the host
                end else if (h_req && h_lock) begin
                    h_sel = 1'b1;
                    nxt   = HBURST;
                end else begin
                    c_sel = arb_c;
                    h_sel = arb_h;
                end
            end
        endcase
    end

    assign c_gnt   = c_sel && !rst;
    assign h_gnt   = h_sel && !rst;
    assign stall   = c_req && !c_gnt;
    assign c_rdata = mem_dout;

    always_comb begin
        mem_we   = (h_gnt && h_we) || (c_gnt && c_we);
        mem_addr = h_gnt ? h_addr : c_addr;
        mem_din  = h_gnt ? h_wdata : c_wdata;
        if (rst) begin
            mem_addr = '0;
            mem_din  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            h_rdata  <= '0;
            h_rvalid <= 1'b0;
        end else begin
            state    <= nxt;
            h_rvalid <= h_gnt && !h_we;
            if (h_gnt && !h_we) h_rdata <= mem_dout;
        end
    end

    arb_sat_counter #(.W(WCW), .MAX(MAX_WAIT)) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (h_gnt || !h_req),
        .inc (h_req && !h_gnt),
        .cnt (wait_cnt)
    );

    arb_sat_counter #(.W(BCW), .MAX(MAX_BURST)) u_burst (
        .clk (clk),
        .rst (rst),
        .clr (nxt == ARB),
        .inc (h_sel && (nxt == HBURST)),
        .cnt (burst_cnt)
    );

endmodule
